seg_display_capture: RTL and testbench

Reverse path for the board's seven-segment output: samples a multiplexed, active-low segment bus and its digit-select strobes and recovers the binary value shown on each digit. Used to verify display drive on hardware, and to read back values from externally driven displays. Each digit pattern must stay stable for a programmable number of cycles before it is accepted. Invalid patterns are flagged, and a per-frame completion pulse is produced.

---
 rtl/seg_display_capture_if.sv | 25 ++
 rtl/seg_display_capture.sv | 172 +++++++++++++++++
 tb/tb_seg_display_capture.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seg_display_capture_if.sv
// Seven-segment capture bus: the multiplexed active-low segment/anode lines
// and the per-digit values recovered from them.
interface seg_display_capture_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   an_in;
  logic [4*DIGITS-1:0] digits_out;
  logic [DIGITS-1:0]   digit_valid;
  logic [DIGITS-1:0]   digit_err;
  logic                update;
  logic                frame_valid;

  // Display-drive side: drives segments and anodes, observes recovered values.
  modport master (
    output seg_in, an_in,
    input  digits_out, digit_valid, digit_err, update, frame_valid
  );

  // Capture side: samples segments and anodes, reports recovered values.
  modport slave (
    input  seg_in, an_in,
    output digits_out, digit_valid, digit_err, update, frame_valid
  );
endinterface

// File: rtl/seg_display_capture.sv
// Recovers the value shown on each digit of a multiplexed, active-low
// seven-segment bus. A digit is accepted only after its segment/anode
// pattern has been stable for STABLE_CYCLES samples; illegal patterns
// are flagged and a pulse marks each completed frame.
module seg_display_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_capture_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Segment pattern to {err, value}; blank shows F, anything unknown is E.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1000000: res = {1'b0, 4'h0};
      7'b1111001: res = {1'b0, 4'h1};
      7'b0100100: res = {1'b0, 4'h2};
      7'b0110000: res = {1'b0, 4'h3};
      7'b0011001: res = {1'b0, 4'h4};
      7'b0010010: res = {1'b0, 4'h5};
      7'b0000010: res = {1'b0, 4'h6};
      7'b1111000: res = {1'b0, 4'h7};
      7'b0000000: res = {1'b0, 4'h8};
      7'b0010000: res = {1'b0, 4'h9};
      7'b1111111: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'hE};
    endcase
    return res;
  endfunction

  logic [6:0]          seg_r;
  logic [DIGITS-1:0]   an_r;
  logic                changed_r;
  logic [7:0]          count_r;
  state_t              state_r;
  state_t              state_next_s;
  logic [DIGITS-1:0]   seen_r;
  logic [4*DIGITS-1:0] digits_r;
  logic [DIGITS-1:0]   valid_r;
  logic [DIGITS-1:0]   err_r;
  logic                update_r;
  logic                frame_r;

  logic                in_diff_s;
  logic [3:0]          zeros_s;
  logic                an_legal_s;
  logic [DIGITS-1:0]   sel_s;
  logic [3:0]          old_val_s;
  logic                old_err_s;
  logic                old_valid_s;
  logic [4:0]          dec_s;
  logic                capture_s;
  logic                change_s;
  logic [DIGITS-1:0]   seen_next_s;
  logic                frame_s;

  assign in_diff_s = ({bus.seg_in, bus.an_in} != {seg_r, an_r});

  // Sample registers and the saturating stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r     <= 7'h7F;
      an_r      <= {DIGITS{1'b1}};
      changed_r <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      seg_r     <= bus.seg_in;
      an_r      <= bus.an_in;
      changed_r <= in_diff_s;
      if (in_diff_s) begin
        count_r <= 8'd1;
      end else if (count_r < STABLE) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Decode which digit is selected and fetch its currently stored state.
  always_comb begin
    zeros_s     = 4'd0;
    old_val_s   = 4'h0;
    old_err_s   = 1'b0;
    old_valid_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      zeros_s = zeros_s + {3'd0, ~an_r[i]};
    end
    an_legal_s = (zeros_s == 4'd1);
    sel_s      = an_legal_s ? ~an_r : {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      old_val_s   = old_val_s   | (digits_r[4*i +: 4] & {4{sel_s[i]}});
      old_err_s   = old_err_s   | (err_r[i]   & sel_s[i]);
      old_valid_s = old_valid_s | (valid_r[i] & sel_s[i]);
    end
  end

  // Next-state logic: capture once per stable run of a legal selection.
  always_comb begin
    state_next_s = state_r;
    if (!an_legal_s) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE, SETTLE:  state_next_s = (count_r == STABLE) ? CAPTURE : SETTLE;
        CAPTURE, HOLD: state_next_s = changed_r ? SETTLE : HOLD;
        default:       state_next_s = IDLE;
      endcase
    end
  end

  // Capture decisions: change detection for update, frame completion.
  always_comb begin
    capture_s   = (state_next_s == CAPTURE);
    dec_s       = decode_seg(seg_r);
    change_s    = capture_s & ((dec_s[3:0] != old_val_s) |
                               (dec_s[4] != old_err_s) | ~old_valid_s);
    seen_next_s = seen_r | sel_s;
    frame_s     = capture_s & (&seen_next_s);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Stored digits, flags, frame tracking and the one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_r <= {(4*DIGITS){1'b0}};
      valid_r  <= {DIGITS{1'b0}};
      err_r    <= {DIGITS{1'b0}};
      seen_r   <= {DIGITS{1'b0}};
      update_r <= 1'b0;
      frame_r  <= 1'b0;
    end else begin
      update_r <= change_s;
      frame_r  <= frame_s;
      for (int i = 0; i < DIGITS; i++) begin
        if (capture_s && sel_s[i]) begin
          digits_r[4*i +: 4] <= dec_s[3:0];
          err_r[i]           <= dec_s[4];
          valid_r[i]         <= 1'b1;
        end
      end
      if (capture_s) begin
        seen_r <= frame_s ? {DIGITS{1'b0}} : seen_next_s;
      end
    end
  end

  assign bus.digits_out  = digits_r;
  assign bus.digit_valid = valid_r;
  assign bus.digit_err   = err_r;
  assign bus.update      = update_r;
  assign bus.frame_valid = frame_r;
endmodule

// File: tb/tb_seg_display_capture.sv
// Bench for seg_display_capture: directed hold table, reset/latency and
// saturation sequences, then random segment/anode activity, all checked
// every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_seg_display_capture;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000};

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    int          hold;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    int          upds;
    int          frms;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_display_capture_if #(.DIGITS(DIGITS)) bus ();
  seg_display_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen, frm_seen;

  // Reference model: displayed digits, and the current run of identical samples.
  int         m_run;
  logic [6:0] m_pseg;
  logic [3:0] m_pan;
  int         m_val   [DIGITS];
  bit         m_err   [DIGITS];
  bit         m_valid [DIGITS];
  bit         m_seen  [DIGITS];
  bit         m_upd, m_frm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pseg = 7'h7F; m_pan = 4'hF; m_upd = 0; m_frm = 0;
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i] = 0; m_err[i] = 0; m_valid[i] = 0; m_seen[i] = 0;
    end
  endtask

  task automatic model_capture(input logic [6:0] seg, input logic [3:0] an);
    int idx = -1;
    int nz  = 0;
    int v   = 14;
    bit e   = 1;
    bit all = 1;
    for (int i = 0; i < DIGITS; i++) if (an[i] == 1'b0) begin nz++; idx = i; end
    if (nz != 1) return;
    for (int p = 0; p < 10; p++) if (seg == PAT[p]) begin v = p; e = 0; end
    if (seg == 7'h7F) begin v = 15; e = 0; end
    m_upd = !m_valid[idx] || (m_val[idx] != v) || (m_err[idx] != e);
    m_val[idx] = v; m_err[idx] = e; m_valid[idx] = 1; m_seen[idx] = 1;
    for (int i = 0; i < DIGITS; i++) all = all & m_seen[i];
    if (all) begin
      m_frm = 1;
      for (int i = 0; i < DIGITS; i++) m_seen[i] = 0;
    end
  endtask

  // A run that has just reached STABLE samples is captured on the following edge.
  task automatic model_edge(input logic [6:0] seg, input logic [3:0] an, input logic r);
    m_upd = 0; m_frm = 0;
    if (r) begin
      model_reset();
    end else begin
      if (m_run == STABLE) model_capture(m_pseg, m_pan);
      if (seg == m_pseg && an == m_pan) m_run++;
      else begin m_run = 1; m_pseg = seg; m_pan = an; end
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic [3:0] an, input logic r);
    logic [15:0] ed;
    logic [3:0]  ev, ee;
    bus.seg_in = seg; bus.an_in = an; rst = r;
    @(posedge clk);
    model_edge(seg, an, r);
    #1;
    for (int i = 0; i < DIGITS; i++) begin
      ed[4*i +: 4] = 4'(m_val[i]); ev[i] = m_valid[i]; ee[i] = m_err[i];
    end
    check("digits_out",  32'(bus.digits_out),  32'(ed));
    check("digit_valid", 32'(bus.digit_valid), 32'(ev));
    check("digit_err",   32'(bus.digit_err),   32'(ee));
    check("update",      32'(bus.update),      32'(m_upd));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_frm));
    if (bus.update) upd_seen++;
    if (bus.frame_valid) frm_seen++;
  endtask

  initial begin
    vec_t       tab [15];
    int         first;
    int         h, sel;
    logic [6:0] rseg;
    logic [3:0] ran;

    tab[0]  = '{7'b0100100, 4'b1110, 10, 16'h0002, 4'b0001, 4'b0000, 1, 0};
    tab[1]  = '{7'b0110000, 4'b1110,  6, 16'h0003, 4'b0001, 4'b0000, 1, 0};
    tab[2]  = '{7'b1000000, 4'b1101,  6, 16'h0003, 4'b0011, 4'b0000, 1, 0};
    tab[3]  = '{7'b1111000, 4'b1011,  6, 16'h0703, 4'b0111, 4'b0000, 1, 0};
    tab[4]  = '{7'b0010000, 4'b0111,  6, 16'h9703, 4'b1111, 4'b0000, 1, 1};
    tab[5]  = '{7'b0110000, 4'b1110,  6, 16'h9703, 4'b1111, 4'b0000, 0, 0};
    tab[6]  = '{7'b1000000, 4'b1101,  6, 16'h9703, 4'b1111, 4'b0000, 0, 0};
    tab[7]  = '{7'b1111000, 4'b1011,  6, 16'h9703, 4'b1111, 4'b0000, 0, 0};
    tab[8]  = '{7'b0010000, 4'b0111,  6, 16'h9703, 4'b1111, 4'b0000, 0, 1};
    tab[9]  = '{7'b0110000, 4'b1101,  3, 16'h9703, 4'b1111, 4'b0000, 0, 0};
    tab[10] = '{7'b0010010, 4'b1101,  5, 16'h9753, 4'b1111, 4'b0000, 1, 0};
    tab[11] = '{7'b0101010, 4'b1011,  6, 16'h9E53, 4'b1111, 4'b0100, 1, 0};
    tab[12] = '{7'b1111111, 4'b1011,  6, 16'h9F53, 4'b1111, 4'b0000, 1, 0};
    tab[13] = '{7'b0000000, 4'b1100, 20, 16'h9F53, 4'b1111, 4'b0000, 0, 0};
    tab[14] = '{7'b0000000, 4'b1111, 20, 16'h9F53, 4'b1111, 4'b0000, 0, 0};

    model_reset();
    upd_seen = 0; frm_seen = 0;
    step(7'h7F, 4'hF, 1'b1);
    step(7'h7F, 4'hF, 1'b1);
    check("reset_digits", 32'(bus.digits_out), 32'h0);
    check("reset_valid",  32'(bus.digit_valid), 32'h0);
    check("reset_err",    32'(bus.digit_err), 32'h0);
    check("reset_pulses", {30'd0, bus.update, bus.frame_valid}, 32'h0);

    // Directed holds: each pattern held for a fixed number of cycles.
    for (int t = 0; t < 15; t++) begin
      upd_seen = 0; frm_seen = 0;
      for (int c = 0; c < tab[t].hold; c++) step(tab[t].seg, tab[t].an, 1'b0);
      check($sformatf("vec%0d_digits", t), 32'(bus.digits_out), 32'(tab[t].digits));
      check($sformatf("vec%0d_valid", t), 32'(bus.digit_valid), 32'(tab[t].valid));
      check($sformatf("vec%0d_err", t), 32'(bus.digit_err), 32'(tab[t].err));
      check($sformatf("vec%0d_updates", t), 32'(upd_seen), 32'(tab[t].upds));
      check($sformatf("vec%0d_frames", t), 32'(frm_seen), 32'(tab[t].frms));
    end

    // Reset in the middle of settling, then full settle latency afterwards.
    step(PAT[8], 4'b1110, 1'b0);
    step(PAT[8], 4'b1110, 1'b0);
    step(PAT[8], 4'b1110, 1'b1);
    check("midrst_digits", 32'(bus.digits_out), 32'h0);
    check("midrst_valid",  32'(bus.digit_valid), 32'h0);
    check("midrst_err",    32'(bus.digit_err), 32'h0);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      step(PAT[8], 4'b1110, 1'b0);
      if (bus.update && first < 0) first = k;
    end
    check("post_reset_latency", 32'(first), 32'd4);
    check("post_reset_digits", 32'(bus.digits_out), 32'h0008);

    // Long hold: counter saturates, no second capture.
    upd_seen = 0; frm_seen = 0;
    for (int k = 0; k < 300; k++) step(PAT[1], 4'b1101, 1'b0);
    check("sat_updates", 32'(upd_seen), 32'd1);
    check("sat_frames",  32'(frm_seen), 32'd0);
    check("sat_digits",  32'(bus.digits_out), 32'h0018);

    // Random activity including glitches, ghosting, illegal anodes and resets.
    rseg = PAT[0]; ran = 4'b1110;
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) rseg = PAT[$urandom_range(0, 9)];
      else if (sel == 6) rseg = 7'h7F;
      else if (sel == 7) rseg = 7'($urandom());
      sel = int'($urandom_range(0, 9));
      if (sel < 8) begin
        ran = 4'hF;
        ran[$urandom_range(0, 3)] = 1'b0;
      end else begin
        ran = 4'($urandom());
      end
      h = int'($urandom_range(1, 7));
      for (int c = 0; c < h; c++) step(rseg, ran, 1'($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
